// File: rtl/zap_bp_pkg.sv
// Shared definitions for the branch predictor state RAM and its controller.
// Contents:
//   bp_state_t      - 2-bit saturating predictor state (SNT/WNT/WT/ST)
//   bp_ctrl_state_t - controller FSM states (SWEEP, IDLE)
//   BP_INIT_STATE   - default value written to every entry on a sweep
//   compute()       - next predictor state from current state and outcome
package zap_bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_state_t;

   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } bp_ctrl_state_t;

   localparam logic [1:0] BP_INIT_STATE = WNT;

   // Saturating 2-bit counter step; fetch uses this to build i_upd_data.
   function automatic bp_state_t compute(input bp_state_t cur, input logic taken);
      bp_state_t nxt;
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = bp_state_t'(cur + 2'b01);
      end else begin
         if (cur != SNT) nxt = bp_state_t'(cur - 2'b01);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/zap_bp_ram_ctrl.sv
// Sequencer and write-port arbiter for the fetch-stage branch state RAM.
//
// state | meaning
// ------+-------------------------------------------------------------
// SWEEP | writing INIT_STATE to entry idx each cycle, updates dropped
// IDLE  | RAM initialised; accepted updates written one cycle later
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_flush_req             restart the initialisation sweep
//   i_stall                 pipeline stall, blocks update acceptance
//   i_upd_valid/addr/data   predictor update from the ALU
//   i_rd_en, i_rd_addr      fetch read qualifier and index (also go to RAM)
//   i_ram_rd_data           RAM read data, one cycle after i_rd_en
//   o_wr_en/addr/data       RAM write port
//   o_taken                 prediction to fetch, with write forwarding
//   o_ready                 high once the RAM is initialised
//   o_upd_drop              an offered update was discarded this cycle
module zap_bp_ram_ctrl
   import zap_bp_pkg::*;
#(
   parameter int          BP_ENTRIES = 1024,
   parameter logic [1:0]  INIT_STATE = BP_INIT_STATE,
   localparam int         IW         = $clog2(BP_ENTRIES)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush_req,
   input  logic          i_stall,
   input  logic          i_upd_valid,
   input  logic [IW-1:0] i_upd_addr,
   input  logic [1:0]    i_upd_data,
   input  logic          i_rd_en,
   input  logic [IW-1:0] i_rd_addr,
   input  logic [1:0]    i_ram_rd_data,
   output logic          o_wr_en,
   output logic [IW-1:0] o_wr_addr,
   output logic [1:0]    o_wr_data,
   output logic [1:0]    o_taken,
   output logic          o_ready,
   output logic          o_upd_drop
);

   localparam logic [IW-1:0] IDX_LAST = IW'(BP_ENTRIES - 1);

   bp_ctrl_state_t state;
   logic [IW-1:0]  idx;
   logic           upd_v;
   logic [IW-1:0]  upd_addr;
   logic [1:0]     upd_data;
   logic           rd_sweep;
   logic           fwd_hit;
   logic [1:0]     fwd_data;

   logic sweeping;
   logic offered;
   logic accept;

   assign sweeping = (state == SWEEP);
   assign offered  = i_upd_valid && !i_stall;
   assign accept   = offered && !sweeping && !i_flush_req;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= SWEEP;
         idx      <= '0;
         upd_v    <= 1'b0;
         upd_addr <= '0;
         upd_data <= '0;
         rd_sweep <= 1'b1;
         fwd_hit  <= 1'b0;
         fwd_data <= INIT_STATE;
      end else begin
         upd_v <= accept;
         if (accept) begin
            upd_addr <= i_upd_addr;
            upd_data <= i_upd_data;
         end

         if (i_flush_req) begin
            state <= SWEEP;
            idx   <= '0;
         end else if (sweeping) begin
            // idx parks on the last entry; the next flush reloads it
            if (idx == IDX_LAST) state <= IDLE;
            else                 idx   <= idx + 1'b1;
         end

         // Capture what the RAM write port does in the read cycle, so the
         // prediction returned next cycle reflects that write.
         if (i_rd_en) begin
            rd_sweep <= sweeping || i_flush_req;
            fwd_hit  <= o_wr_en && (i_rd_addr == o_wr_addr);
            fwd_data <= o_wr_data;
         end
      end
   end

   assign o_wr_en    = sweeping || upd_v;
   assign o_wr_addr  = sweeping ? idx : upd_addr;
   assign o_wr_data  = sweeping ? INIT_STATE : upd_data;
   assign o_ready    = !sweeping;
   assign o_upd_drop = offered && !accept;
   assign o_taken    = rd_sweep ? INIT_STATE :
                       fwd_hit  ? fwd_data   : i_ram_rd_data;

endmodule

// File: tb/tb_zap_bp_ram_ctrl.sv
module tb_zap_bp_ram_ctrl;
   import zap_bp_pkg::*;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          stall;
   logic          upd_valid;
   logic [IW-1:0] upd_addr;
   logic [1:0]    upd_data;
   logic          rd_en;
   logic [IW-1:0] rd_addr;
   logic [1:0]    ram_rd_data;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [1:0]    wr_data;
   logic [1:0]    taken;
   logic          ready;
   logic          upd_drop;

   int n_checks = 0;
   int n_fail   = 0;

   zap_bp_ram_ctrl #(.BP_ENTRIES(N), .INIT_STATE(2'b01)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_flush_req   (flush),
      .i_stall       (stall),
      .i_upd_valid   (upd_valid),
      .i_upd_addr    (upd_addr),
      .i_upd_data    (upd_data),
      .i_rd_en       (rd_en),
      .i_rd_addr     (rd_addr),
      .i_ram_rd_data (ram_rd_data),
      .o_wr_en       (wr_en),
      .o_wr_addr     (wr_addr),
      .o_wr_data     (wr_data),
      .o_taken       (taken),
      .o_ready       (ready),
      .o_upd_drop    (upd_drop)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; stall = 1'b0; upd_valid = 1'b0;
      upd_addr = '0; upd_data = '0; rd_en = 1'b0; rd_addr = '0; ram_rd_data = 2'b11;
      @(negedge clk); @(negedge clk);
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL reset_wr_en got %b want 1", wr_en); end
      n_checks++; if (wr_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
      n_checks++; if (wr_data !== 2'b01) begin n_fail++; $display("FAIL reset_wr_data got %b want 01", wr_data); end
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
      n_checks++; if (upd_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", upd_drop); end
      n_checks++; if (taken !== 2'b01) begin n_fail++; $display("FAIL reset_taken got %b want 01", taken); end
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (wr_en !== 1'b1 || wr_addr !== 3'(k) || wr_data !== 2'b01 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_%0d got en=%b addr=%0d data=%b rdy=%b want en=1 addr=%0d data=01 rdy=0",
                     k, wr_en, wr_addr, wr_data, ready, k);
         end
         if (k == 2) begin
            upd_valid = 1'b1; upd_addr = 3'd4; upd_data = 2'b11;
            #1;
            n_checks++; if (upd_drop !== 1'b1) begin n_fail++; $display("FAIL sweep_drop got %b want 1", upd_drop); end
         end
         @(negedge clk);
         upd_valid = 1'b0;
      end
      n_checks++;
      if (ready !== 1'b1 || wr_en !== 1'b0) begin
         n_fail++; $display("FAIL sweep_done got rdy=%b en=%b want rdy=1 en=0", ready, wr_en);
      end
   endtask

   task automatic test_update();
      upd_valid = 1'b1; upd_addr = 3'd5; upd_data = 2'b11; #1;
      n_checks++; if (upd_drop !== 1'b0) begin n_fail++; $display("FAIL upd_drop got %b want 0", upd_drop); end
      @(negedge clk);
      upd_valid = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'd5 || wr_data !== 2'b11) begin
         n_fail++; $display("FAIL upd_write got en=%b addr=%0d data=%b want en=1 addr=5 data=11", wr_en, wr_addr, wr_data);
      end
      @(negedge clk);
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL upd_idle got %b want 0", wr_en); end
      // stalled update: neither accepted nor reported as dropped
      upd_valid = 1'b1; stall = 1'b1; upd_addr = 3'd6; upd_data = 2'b10; #1;
      n_checks++; if (upd_drop !== 1'b0) begin n_fail++; $display("FAIL stall_drop got %b want 0", upd_drop); end
      @(negedge clk);
      upd_valid = 1'b0; stall = 1'b0;
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_write got %b want 0", wr_en); end
   endtask

   task automatic test_back_to_back();
      upd_valid = 1'b1; upd_addr = 3'd1; upd_data = 2'b10;
      @(negedge clk);
      upd_addr = 3'd1; upd_data = 2'b11;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 2'b10) begin
         n_fail++; $display("FAIL b2b_first got en=%b addr=%0d data=%b want en=1 addr=1 data=10", wr_en, wr_addr, wr_data);
      end
      @(negedge clk);
      upd_valid = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 2'b11) begin
         n_fail++; $display("FAIL b2b_second got en=%b addr=%0d data=%b want en=1 addr=1 data=11", wr_en, wr_addr, wr_data);
      end
      @(negedge clk);
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", wr_en); end
   endtask

   task automatic test_forward();
      upd_valid = 1'b1; upd_addr = 3'd3; upd_data = 2'b10;
      @(negedge clk);
      upd_valid = 1'b0; rd_en = 1'b1; rd_addr = 3'd3; ram_rd_data = 2'b01;
      @(negedge clk);
      n_checks++; if (taken !== 2'b10) begin n_fail++; $display("FAIL fwd_hit got %b want 10", taken); end
      // non-matching read with no write in flight returns RAM data
      rd_addr = 3'd4; ram_rd_data = 2'b00;
      @(negedge clk);
      rd_en = 1'b0;
      n_checks++; if (taken !== 2'b00) begin n_fail++; $display("FAIL fwd_miss got %b want 00", taken); end
      ram_rd_data = 2'b11; #1;
      n_checks++; if (taken !== 2'b11) begin n_fail++; $display("FAIL rd_hold got %b want 11", taken); end
   endtask

   task automatic test_flush_update();
      int writes;
      flush = 1'b1; upd_valid = 1'b1; upd_addr = 3'd2; upd_data = 2'b11; #1;
      n_checks++; if (upd_drop !== 1'b1) begin n_fail++; $display("FAIL flush_drop got %b want 1", upd_drop); end
      @(negedge clk);
      flush = 1'b0; upd_valid = 1'b0; ram_rd_data = 2'b11;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 2'b01) begin
         n_fail++; $display("FAIL flush_start got en=%b addr=%0d data=%b want en=1 addr=0 data=01", wr_en, wr_addr, wr_data);
      end
      // restart the sweep while writing index 3: 0,1,2,3 then 0..7
      writes = 0;
      for (int k = 0; k < 12; k++) begin
         automatic int exp_a = (k < 4) ? k : k - 4;
         n_checks++;
         if (wr_en !== 1'b1 || wr_addr !== 3'(exp_a)) begin
            n_fail++; $display("FAIL flush_seq_%0d got en=%b addr=%0d want en=1 addr=%0d", k, wr_en, wr_addr, exp_a);
         end
         if (wr_en === 1'b1) writes++;
         flush = (k == 3);
         rd_en = (k == 5); rd_addr = 3'd6;
         if (k == 6) begin
            n_checks++; if (taken !== 2'b01) begin n_fail++; $display("FAIL sweep_read got %b want 01", taken); end
         end
         @(negedge clk);
      end
      flush = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (writes != 12 || ready !== 1'b1 || wr_en !== 1'b0) begin
         n_fail++; $display("FAIL flush_total got writes=%0d rdy=%b en=%b want writes=12 rdy=1 en=0", writes, ready, wr_en);
      end
   endtask

   task automatic test_reset_mid_update();
      int cyc;
      upd_valid = 1'b1; upd_addr = 3'd7; upd_data = 2'b00;
      @(negedge clk);
      upd_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 2'b01) begin
         n_fail++; $display("FAIL rst_mid got en=%b addr=%0d data=%b want en=1 addr=0 data=01", wr_en, wr_addr, wr_data);
      end
      cyc = 0;
      while (ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      n_checks++;
      if (cyc != N) begin n_fail++; $display("FAIL rst_mid_len got %0d cycles want %0d", cyc, N); end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_update();
      test_back_to_back();
      test_forward();
      test_flush_update();
      test_reset_mid_update();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
